// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int DEFAULT_BAUD_DIV = 2604;
   localparam int FRAME_BITS       = 8;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous input; both stages reset to 1 (line idle level).
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: mid-bit sampling of RX into parallel bytes with a rdy handshake.
// Optional stop-bit check enabled by defining UART_RCV_FRAMING_ERR_EN.
module uart_rcv
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err
);

   localparam int              HALF_DIV  = BAUD_DIV / 2;
   localparam int              CW        = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]   HALF_LOAD = CW'(HALF_DIV - 1);
   localparam logic [CW-1:0]   BAUD_LOAD = CW'(BAUD_DIV - 1);
   localparam logic [3:0]      LAST_BIT  = 4'(FRAME_BITS - 1);

   rx_state_e             state_q, state_d;
   logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [7:0]            rx_data_q, rx_data_d;
   logic                  rdy_q, rdy_d;
   logic                  rx_prev_q, rx_prev_d;
   logic                  rx_sync;
   logic                  start_det;
   logic                  baud_zero;
   logic                  rdy_set;

   uart_sync2 u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (RX),
      .q   (rx_sync)
   );

   assign start_det = (state_q == IDLE) && !rx_sync && rx_prev_q;
   assign baud_zero = (baud_cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_det) state_d = START;
         START: if (baud_zero) state_d = rx_sync ? IDLE : DATA;
         DATA:  if (baud_zero && (bit_cnt_q == LAST_BIT)) state_d = STOP;
         STOP:  if (baud_zero) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Counters reload at zero rather than wrapping, so every sample lands mid-bit.
   always_comb begin
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      rx_prev_d  = rx_sync;
      rdy_set    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_det) begin
               baud_cnt_d = HALF_LOAD;
               bit_cnt_d  = '0;
            end
         end
         START: begin
            baud_cnt_d = baud_zero ? BAUD_LOAD : baud_cnt_q - CW'(1);
         end
         DATA: begin
            if (baud_zero) begin
               shift_d    = {rx_sync, shift_q[FRAME_BITS-1:1]};
               bit_cnt_d  = bit_cnt_q + 4'd1;
               baud_cnt_d = BAUD_LOAD;
            end else begin
               baud_cnt_d = baud_cnt_q - CW'(1);
            end
         end
         STOP: begin
            if (baud_zero) begin
               rx_data_d = shift_q;
               rdy_set   = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q - CW'(1);
            end
         end
         default: begin
            baud_cnt_d = '0;
         end
      endcase
      rdy_d = rdy_set | (rdy_q & ~(clr_rdy | start_det));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rdy_q      <= 1'b0;
         rx_prev_q  <= 1'b1;
      end else begin
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rdy_q      <= rdy_d;
         rx_prev_q  <= rx_prev_d;
      end
   end

`ifdef UART_RCV_FRAMING_ERR_EN
   logic frm_err_q, frm_err_d;

   // Follows rdy: set with each delivered byte, cleared by the same events.
   always_comb begin
      frm_err_d = frm_err_q;
      if (rdy_set)                   frm_err_d = ~rx_sync;
      else if (clr_rdy || start_det) frm_err_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) frm_err_q <= 1'b0;
      else     frm_err_q <= frm_err_d;
   end

   assign frm_err = frm_err_q;
`else
   assign frm_err = 1'b0;
`endif

   assign rx_data = rx_data_q;
   assign rdy     = rdy_q;

endmodule

// File: tb/tb_uart_rcv.sv
// Self-checking bench for uart_rcv: a fast instance (BAUD_DIV=16) and one at the full 2604 divider.
module tb_uart_rcv;

   localparam int B  = 16;
   localparam int H  = B / 2;
   localparam int BF = 2604;
`ifdef UART_RCV_FRAMING_ERR_EN
   localparam bit FE_EN = 1'b1;
`else
   localparam bit FE_EN = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop_bit;
      int         clr_mode;
      int         gap;
      logic [7:0] exp_data;
      logic       exp_frm;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       frm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_full = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data, rx_data_f;
   logic       rdy, rdy_f;
   logic       frm_err, frm_err_f;

   int checks = 0;
   int errors = 0;

   uart_rcv #(.BAUD_DIV(B)) dut (
      .clk     (clk),
      .rst     (rst),
      .RX      (rx),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err)
   );

   uart_rcv #(.BAUD_DIV(BF)) dut_full (
      .clk     (clk),
      .rst     (rst),
      .RX      (rx_full),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data_f),
      .rdy     (rdy_f),
      .frm_err (frm_err_f)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: the byte comes back unchanged; frm_err reports a low stop bit when enabled.
   function automatic exp_t refModel(input logic [7:0] data, input logic stop_bit);
      exp_t e;
      e.data = data;
      e.frm  = FE_EN && !stop_bit;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame starting at a negedge and watches for rdy while the frame is on the line.
   // clr_mode: 0 leave rdy, 1 pulse clr_rdy after rdy is seen, 2 hold clr_rdy for the whole frame.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int clr_mode,
                                input int gap, input bit full, input logic [7:0] exp_data,
                                input logic exp_frm);
      int         bd, total, seen, lat_exp, cnt, bit_idx;
      logic       v, cur_rdy, got_next, got_frm;
      logic [7:0] got_data;
      bd       = full ? BF : B;
      total    = 10 * bd + gap;
      lat_exp  = 2 + bd / 2 + 9 * bd;
      seen     = -1;
      got_next = 1'bx;
      got_data = 8'hxx;
      got_frm  = 1'bx;
      if (clr_mode == 2) clr_rdy = 1'b1;
      for (int c = 0; c < total + 2 * bd; c++) begin
         bit_idx = c / bd;
         if (c >= total)        v = (gap > 0) ? 1'b1 : stop_bit;
         else if (bit_idx == 0) v = 1'b0;
         else if (bit_idx <= 8) v = data[bit_idx-1];
         else if (bit_idx == 9) v = stop_bit;
         else                   v = 1'b1;
         if (full) rx_full = v;
         else      rx = v;
         @(negedge clk);
         cnt     = c + 1;
         cur_rdy = full ? rdy_f : rdy;
         if (seen < 0 && cnt > 3 && cur_rdy === 1'b1) begin
            seen     = cnt;
            got_data = full ? rx_data_f : rx_data;
            got_frm  = full ? frm_err_f : frm_err;
            if (clr_mode == 1) clr_rdy = 1'b1;
         end else if (seen >= 0 && cnt == seen + 1) begin
            got_next = cur_rdy;
            if (clr_mode == 1) clr_rdy = 1'b0;
         end
         if (c >= total - 1 && seen >= 0 && cnt > seen + 1) break;
      end
      clr_rdy = 1'b0;
      checkOutput("rdy_seen", (seen >= 0), 1'b1);
      if (seen >= 0) begin
         checks++;
         if (seen < lat_exp - 1 || seen > lat_exp + 1) begin
            errors++;
            $display("[TB] FAIL latency actual=%0d expected=%0d+/-1", seen, lat_exp);
         end
         checkOutput("rx_data", got_data, exp_data);
         checkOutput("frm_err", got_frm, exp_frm);
         if (clr_mode != 0) checkOutput("rdy_after_clr", got_next, 1'b0);
      end
   endtask

   vec_t vecs[7];

   initial begin
      exp_t e;
      int   hi_count;
      logic [7:0] rd;
      logic st;

      vecs[0] = '{8'hA5, 1'b1, 1, B, 8'hA5, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF, 1'b0};
      vecs[3] = '{8'h55, 1'b1, 1, 0, 8'h55, 1'b0};
      vecs[4] = '{8'h3C, 1'b1, 1, B, 8'h3C, 1'b0};
      vecs[5] = '{8'h81, 1'b0, 0, B, 8'h81, FE_EN};
      vecs[6] = '{8'hC3, 1'b1, 2, B, 8'hC3, 1'b0};

      // Reset state
      idleCycles(3);
      checkOutput("reset_rdy", rdy, 1'b0);
      checkOutput("reset_rx_data", rx_data, 8'h00);
      checkOutput("reset_frm_err", frm_err, 1'b0);
      checkOutput("reset_rdy_full", rdy_f, 1'b0);
      rst = 1'b0;
      idleCycles(4);

      // Single frame, back-to-back burst, bad stop bit, clr_rdy colliding with set
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].data, vecs[i].stop_bit, vecs[i].clr_mode, vecs[i].gap, 1'b0,
                       vecs[i].exp_data, vecs[i].exp_frm);
      end

      // Short low glitch is rejected as a false start
      rx = 1'b0;
      idleCycles(H - 2);
      rx = 1'b1;
      idleCycles(2 * B);
      checkOutput("glitch_rdy", rdy, 1'b0);
      checkOutput("glitch_rx_data", rx_data, 8'hC3);
      applyStimulus(8'h6B, 1'b1, 1, B, 1'b0, 8'h6B, 1'b0);

      // Reset in the middle of a data phase drops the frame
      applyStimulus(8'h5A, 1'b1, 0, B, 1'b0, 8'h5A, 1'b0);
      rx = 1'b0;
      idleCycles(B);
      for (int k = 0; k < 3; k++) begin
         rx = (8'h7E >> k) & 8'h01;
         idleCycles(B);
      end
      rst = 1'b1;
      rx  = 1'b1;
      idleCycles(1);
      rst = 1'b0;
      checkOutput("midrst_rdy", rdy, 1'b0);
      checkOutput("midrst_rx_data", rx_data, 8'h00);
      checkOutput("midrst_frm_err", frm_err, 1'b0);
      idleCycles(B);
      applyStimulus(8'h12, 1'b1, 1, B, 1'b0, 8'h12, 1'b0);

      // Break: RX held low gives one 0x00 frame and nothing more
      applyStimulus(8'h00, 1'b0, 1, 0, 1'b0, 8'h00, FE_EN);
      hi_count = 0;
      for (int k = 0; k < 3 * B; k++) begin
         @(negedge clk);
         if (rdy === 1'b1) hi_count++;
      end
      checkOutput("break_no_repeat", hi_count, 0);
      rx = 1'b1;
      idleCycles(B);

      // Randomized frames against the reference model
      for (int i = 0; i < 10; i++) begin
         rd = 8'($urandom_range(0, 255));
         st = ($urandom_range(0, 3) != 0);
         e  = refModel(rd, st);
         applyStimulus(rd, st, int'($urandom_range(0, 1)), st ? int'($urandom_range(0, B)) : B,
                       1'b0, e.data, e.frm);
      end

      // One frame at the full divider
      e = refModel(8'h96, 1'b1);
      applyStimulus(8'h96, 1'b1, 1, 16, 1'b1, e.data, e.frm);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
